clock_freq_monitor: RTL and testbench

- Measures the frequency of a generated clock (nominally the 12.288 MHz audio clock from the PLL/divider) against the 50 MHz reference.
- Counts rising edges of the monitored clock over a fixed gate window of reference cycles, reports each window's count, and runs a lock detector.
- Sits beside the clock generator in the reference domain and gives status logic a `locked` indication before the audio path is released.

---
 rtl/clock_pkg.sv | 20 ++
 rtl/clock_edge_sync.sv | 27 ++
 rtl/clock_freq_monitor.sv | 168 ++++++++++++++++
 tb/tb_clock_freq_monitor.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// Shared definitions for the clock frequency monitor and its helpers:
// the lock FSM encoding and the nominal clock rates the defaults derive from.
package clock_pkg;

  // Lock detector states
  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'd0,
    ST_ACQUIRE  = 2'd1,
    ST_LOCKED   = 2'd2
  } lock_state_e;

  // Nominal reference and monitored clock rates in Hz
  localparam int REF_CLK_HZ = 50_000_000;
  localparam int MON_CLK_HZ = 12_288_000;

  // A 1 ms gate window at the reference rate, and the edges expected in it
  localparam int NOM_GATE_CYCLES = REF_CLK_HZ / 1000;
  localparam int NOM_EXP_COUNT   = MON_CLK_HZ / (REF_CLK_HZ / NOM_GATE_CYCLES);

endpackage

// File: rtl/clock_edge_sync.sv
// Brings an asynchronous level into the clk domain through two flops, then
// a third delay flop, and flags a rising edge as a single-cycle pulse.
module clock_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic async_i,
  output logic rise_o
);

  logic s1_q, s2_q, s3_q;

  // Synchronizer chain plus delay flop used for edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= async_i;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign rise_o = s2_q & ~s3_q;

endmodule

// File: rtl/clock_freq_monitor.sv
// Counts monitored-clock rising edges over a fixed window of reference
// cycles, reports the count with range/stuck flags and tracks lock status.
module clock_freq_monitor
  import clock_pkg::*;
#(
  parameter int GATE_CYCLES  = NOM_GATE_CYCLES,
  parameter int EXP_COUNT    = NOM_EXP_COUNT,
  parameter int TOL          = 64,
  parameter int LOCK_WINDOWS = 4,
  parameter int CNT_W        = 16
) (
  input  logic             refclk,
  input  logic             rst,
  input  logic             mon_clk,
  input  logic             enable,
  output logic [CNT_W-1:0] count,
  output logic             count_valid,
  output logic             in_range,
  output logic             locked,
  output logic             lock_lost,
  output logic             stuck
);

  localparam int GATE_W = $clog2(GATE_CYCLES);
  localparam int GOOD_W = $clog2(LOCK_WINDOWS + 1);
  localparam logic [GATE_W-1:0] GATE_LAST   = GATE_W'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX     = '1;
  localparam logic [GOOD_W-1:0] GOOD_TARGET = GOOD_W'(LOCK_WINDOWS);

  logic              edgePulse;
  logic              terminal;
  logic              windowGood;
  logic [CNT_W-1:0]  edgeSum;
  int                windowDiff;
  int                windowAbs;
  logic [GOOD_W-1:0] goodInc;

  logic [GATE_W-1:0] gate_q, gate_d;
  logic [CNT_W-1:0]  edge_q, edge_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              valid_q, valid_d;
  logic              inRange_q, inRange_d;
  logic              stuck_q, stuck_d;
  lock_state_e       state_q, state_d;
  logic [GOOD_W-1:0] good_q, good_d;
  logic              locked_q, locked_d;
  logic              lost_q, lost_d;

  clock_edge_sync u_edge_sync (
    .clk     (refclk),
    .rst     (rst),
    .async_i (mon_clk),
    .rise_o  (edgePulse)
  );

  // Gate/edge counting and the per-window result latched at window close
  always_comb begin
    terminal   = enable && (gate_q == GATE_LAST);
    edgeSum    = (edgePulse && (edge_q != CNT_MAX)) ? edge_q + 1'b1 : edge_q;
    windowDiff = int'(edgeSum) - EXP_COUNT;
    windowAbs  = (windowDiff < 0) ? -windowDiff : windowDiff;
    windowGood = (windowAbs <= TOL);
    gate_d     = gate_q;
    edge_d     = edge_q;
    count_d    = count_q;
    valid_d    = 1'b0;
    inRange_d  = inRange_q;
    stuck_d    = stuck_q;
    if (!enable) begin
      gate_d = '0;
      edge_d = '0;
    end else if (terminal) begin
      gate_d    = '0;
      edge_d    = '0;
      count_d   = edgeSum;
      valid_d   = 1'b1;
      inRange_d = windowGood;
      stuck_d   = (edgeSum == '0);
    end else begin
      gate_d = gate_q + 1'b1;
      edge_d = edgeSum;
    end
  end

  // Lock FSM next state; only a window close or enable low moves it
  always_comb begin
    goodInc = good_q + 1'b1;
    state_d = state_q;
    good_d  = good_q;
    lost_d  = 1'b0;
    if (!enable) begin
      state_d = ST_UNLOCKED;
      good_d  = '0;
    end else if (terminal) begin
      unique case (state_q)
        ST_UNLOCKED: begin
          if (windowGood) begin
            if (LOCK_WINDOWS == 1) begin
              state_d = ST_LOCKED;
              good_d  = '0;
            end else begin
              state_d = ST_ACQUIRE;
              good_d  = GOOD_W'(1);
            end
          end
        end
        ST_ACQUIRE: begin
          if (!windowGood) begin
            state_d = ST_UNLOCKED;
            good_d  = '0;
          end else if (goodInc == GOOD_TARGET) begin
            state_d = ST_LOCKED;
            good_d  = '0;
          end else begin
            good_d = goodInc;
          end
        end
        ST_LOCKED: begin
          if (!windowGood) begin
            state_d = ST_UNLOCKED;
            good_d  = '0;
            lost_d  = 1'b1;
          end
        end
        default: begin
          state_d = ST_UNLOCKED;
          good_d  = '0;
        end
      endcase
    end
    locked_d = (state_d == ST_LOCKED);
  end

  // All state and registered outputs
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      gate_q    <= '0;
      edge_q    <= '0;
      count_q   <= '0;
      valid_q   <= 1'b0;
      inRange_q <= 1'b0;
      stuck_q   <= 1'b0;
      state_q   <= ST_UNLOCKED;
      good_q    <= '0;
      locked_q  <= 1'b0;
      lost_q    <= 1'b0;
    end else begin
      gate_q    <= gate_d;
      edge_q    <= edge_d;
      count_q   <= count_d;
      valid_q   <= valid_d;
      inRange_q <= inRange_d;
      stuck_q   <= stuck_d;
      state_q   <= state_d;
      good_q    <= good_d;
      locked_q  <= locked_d;
      lost_q    <= lost_d;
    end
  end

  assign count       = count_q;
  assign count_valid = valid_q;
  assign in_range    = inRange_q;
  assign locked      = locked_q;
  assign lock_lost   = lost_q;
  assign stuck       = stuck_q;

endmodule

// File: tb/tb_clock_freq_monitor.sv
// Directed bench for clock_freq_monitor: reset, lock acquisition and loss,
// tolerance boundaries, saturation (narrow instance) and enable handling.
module tb_clock_freq_monitor;

  logic       refclk   = 1'b0;
  logic       rst      = 1'b1;
  logic       enable   = 1'b1;
  logic       divClk   = 1'b0;
  logic       burstClk = 1'b0;
  logic       mon_clk;
  int         div      = 0;
  int         phase    = 0;

  logic [7:0] count;
  logic       count_valid, in_range, locked, lock_lost, stuck;
  logic [3:0] satCount;
  logic       satValid, satInRange, satLocked, satLockLost, satStuck;

  int checks = 0;
  int passed = 0;

  // 100 MHz-ish reference, period 10
  always #5 refclk = ~refclk;

  // Monitored clock is a free-running divider OR'ed with hand-made bursts
  assign mon_clk = divClk | burstClk;

  // Divider: toggles every div/2 reference cycles, 2 ns after the edge
  always @(posedge refclk) begin
    #2;
    if (div == 0) begin
      divClk = 1'b0;
      phase  = 0;
    end else begin
      phase++;
      if (phase >= div / 2) begin
        divClk = ~divClk;
        phase  = 0;
      end
    end
  end

  clock_freq_monitor #(
    .GATE_CYCLES(100), .EXP_COUNT(25), .TOL(1), .LOCK_WINDOWS(4), .CNT_W(8)
  ) dut (
    .refclk(refclk), .rst(rst), .mon_clk(mon_clk), .enable(enable),
    .count(count), .count_valid(count_valid), .in_range(in_range),
    .locked(locked), .lock_lost(lock_lost), .stuck(stuck)
  );

  clock_freq_monitor #(
    .GATE_CYCLES(100), .EXP_COUNT(25), .TOL(1), .LOCK_WINDOWS(4), .CNT_W(4)
  ) dutSat (
    .refclk(refclk), .rst(rst), .mon_clk(mon_clk), .enable(enable),
    .count(satCount), .count_valid(satValid), .in_range(satInRange),
    .locked(satLocked), .lock_lost(satLockLost), .stuck(satStuck)
  );

  // Single comparison point: counts every check and reports mismatches
  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    if (observed == expected) passed++;
    else $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
  endtask

  // Produces n monitored-clock rising edges, one every 3 reference cycles
  task automatic applyStimulus(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge refclk); #2 burstClk = 1'b1;
      @(posedge refclk); #2 burstClk = 1'b0;
      @(posedge refclk);
    end
  endtask

  // Waits (bounded) for the next count_valid of either instance, sampling on negedges
  task automatic waitValid(input bit useSat, output int cycles);
    bit seen;
    seen   = 1'b0;
    cycles = 0;
    while (!seen && cycles < 400) begin
      @(negedge refclk);
      cycles++;
      seen = useSat ? satValid : count_valid;
    end
    if (!seen) checkOutput("valid_timeout", 0, 1);
  endtask

  // Directed scenario sequence
  initial begin
    int cyc;
    int heldCount;
    bit anyLost;
    int burstN[7]     = '{24, 26, 23, 25, 25, 25, 25};
    int burstRange[7] = '{1, 1, 0, 1, 1, 1, 1};
    int burstLock[7]  = '{0, 0, 0, 0, 0, 0, 1};

    $display("[TB] start");
    repeat (3) @(negedge refclk);
    checkOutput("rst_count", int'(count), 0);
    checkOutput("rst_valid", int'(count_valid), 0);
    checkOutput("rst_in_range", int'(in_range), 0);
    checkOutput("rst_locked", int'(locked), 0);
    checkOutput("rst_lock_lost", int'(lock_lost), 0);
    checkOutput("rst_stuck", int'(stuck), 0);
    rst = 1'b0;

    // Idle mon_clk: first window closes 100 cycles after release with zero edges
    waitValid(1'b0, cyc);
    checkOutput("idle_latency", cyc, 100);
    checkOutput("idle_count", int'(count), 0);
    checkOutput("idle_stuck", int'(stuck), 1);
    checkOutput("idle_in_range", int'(in_range), 0);

    // refclk/4: 25 edges per window, lock on the 4th good window
    div = 4;
    for (int w = 1; w <= 4; w++) begin
      waitValid(1'b0, cyc);
      if (w == 1) checkOutput("acq_count_w1", int'(count == 8'd24 || count == 8'd25), 1);
      else        checkOutput($sformatf("acq_count_w%0d", w), int'(count), 25);
      checkOutput($sformatf("acq_in_range_w%0d", w), int'(in_range), 1);
      checkOutput($sformatf("acq_locked_w%0d", w), int'(locked), (w == 4) ? 1 : 0);
    end

    // refclk/8 while locked: window fails, lock drops with a one-cycle lost pulse
    div = 8;
    waitValid(1'b0, cyc);
    checkOutput("loss_count_range", int'(count >= 8'd12 && count <= 8'd14), 1);
    checkOutput("loss_in_range", int'(in_range), 0);
    checkOutput("loss_locked", int'(locked), 0);
    checkOutput("loss_lock_lost", int'(lock_lost), 1);
    @(negedge refclk);
    checkOutput("loss_lost_pulse_end", int'(lock_lost), 0);
    checkOutput("loss_valid_pulse_end", int'(count_valid), 0);

    // Exact edge bursts: 24/26 pass, 23 restarts acquisition
    div = 0;
    waitValid(1'b0, cyc);
    for (int b = 0; b < 7; b++) begin
      applyStimulus(burstN[b]);
      waitValid(1'b0, cyc);
      checkOutput($sformatf("tol_count_b%0d", b), int'(count), burstN[b]);
      checkOutput($sformatf("tol_in_range_b%0d", b), int'(in_range), burstRange[b]);
      checkOutput($sformatf("tol_locked_b%0d", b), int'(locked), burstLock[b]);
    end

    // Enable dropped while locked: no lost pulse, results hold, fresh window after
    div = 4;
    repeat (30) @(negedge refclk);
    checkOutput("en_pre_locked", int'(locked), 1);
    heldCount = int'(count);
    enable  = 1'b0;
    anyLost = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge refclk);
      anyLost |= lock_lost;
      if (i == 0) checkOutput("en_locked_off", int'(locked), 0);
    end
    checkOutput("en_no_lock_lost", int'(anyLost), 0);
    checkOutput("en_count_hold", int'(count), 25);
    checkOutput("en_count_hold_prev", int'(count), heldCount);
    checkOutput("en_in_range_hold", int'(in_range), 1);
    enable = 1'b1;
    waitValid(1'b0, cyc);
    checkOutput("en_restart_latency", cyc, 100);
    checkOutput("en_restart_count", int'(count == 8'd24 || count == 8'd25), 1);
    checkOutput("en_restart_locked", int'(locked), 0);

    // refclk/2 into the 4-bit instance: saturates at 15 instead of wrapping
    div = 2;
    waitValid(1'b1, cyc);
    waitValid(1'b1, cyc);
    checkOutput("sat_count", int'(satCount), 15);
    checkOutput("sat_in_range", int'(satInRange), 0);
    checkOutput("sat_stuck", int'(satStuck), 0);
    checkOutput("sat_wide_count", int'(count), 50);

    // Mid-window reset clears every output at once
    repeat (37) @(negedge refclk);
    #2 rst = 1'b1;
    div = 0;
    #1;
    checkOutput("mid_rst_count", int'(count), 0);
    checkOutput("mid_rst_sat_count", int'(satCount), 0);
    checkOutput("mid_rst_in_range", int'(in_range), 0);
    checkOutput("mid_rst_locked", int'(locked), 0);
    checkOutput("mid_rst_stuck", int'(stuck), 0);
    checkOutput("mid_rst_valid", int'(count_valid), 0);
    repeat (3) @(negedge refclk);
    rst = 1'b0;
    waitValid(1'b0, cyc);
    checkOutput("post_rst_latency", cyc, 100);
    checkOutput("post_rst_count", int'(count), 0);
    checkOutput("post_rst_stuck", int'(stuck), 1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
